key_cmd: RTL

KEY_CMD -- requirements
Module: key_cmd

---
 rtl/key_cmd_if.sv | 21 ++
 rtl/key_cmd.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_if.sv
// Command handshake bundle between key_cmd (master) and its consumer (slave).
interface key_cmd_if;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;
    logic       cmd_drop;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_drop,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_drop,
        output cmd_ready
    );
endinterface

// File: rtl/key_cmd.sv
// Turns active-low key presses into direction commands through a 2-entry FIFO.
// Define KEY_CMD_REPEAT_EN to build the hold/auto-repeat FSM.
module key_cmd #(
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    key_cmd_if.master  cmd
);

    localparam logic [15:0] delay_last  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] period_last = 16'(REPEAT_PERIOD - 1);

    logic [3:0] key_prev_r;
    logic [3:0] press_vec_s;
    logic       press_s;
    logic [1:0] press_dir_s;
    logic       rpt_event_s;
    logic [1:0] held_s;

    logic       push_s;
    logic [1:0] push_dir_s;
    logic       pop_s;
    logic       accept_s;
    logic [1:0] mem_r [0:1];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       cmd_drop_r;

    // Previous key sample for falling-edge (press) detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev_r <= 4'b1111;
        end else begin
            key_prev_r <= key_in;
        end
    end

    // Press detection with lowest-index priority
    always_comb begin
        press_vec_s = key_prev_r & ~key_in;
        press_s     = |press_vec_s;
        if (press_vec_s[0]) begin
            press_dir_s = 2'd0;
        end else if (press_vec_s[1]) begin
            press_dir_s = 2'd1;
        end else if (press_vec_s[2]) begin
            press_dir_s = 2'd2;
        end else if (press_vec_s[3]) begin
            press_dir_s = 2'd3;
        end else begin
            press_dir_s = 2'd0;
        end
    end

`ifdef KEY_CMD_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [1:0]  held_r;
    logic [1:0]  held_nxt_s;

    // Hold FSM state, counter and held-key registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            held_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            held_r  <= held_nxt_s;
        end
    end

    // Next state: a fresh press always restarts the hold, then release, then terminal count
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        held_nxt_s  = held_r;
        if (press_s) begin
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = 16'd0;
            held_nxt_s  = press_dir_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end
                ST_HOLD: begin
                    if (key_in[held_r]) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 16'd0;
                    end else if (cnt_r == delay_last) begin
                        state_nxt_s = ST_RPT;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 16'd1;
                    end
                end
                ST_RPT: begin
                    if (key_in[held_r]) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 16'd0;
                    end else if (cnt_r == period_last) begin
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end
            endcase
        end
    end

    // Repeat event output of the hold FSM
    always_comb begin
        rpt_event_s = 1'b0;
        if (press_s) begin
            rpt_event_s = 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: rpt_event_s = !key_in[held_r] && (cnt_r == delay_last);
                ST_RPT:  rpt_event_s = !key_in[held_r] && (cnt_r == period_last);
                default: rpt_event_s = 1'b0;
            endcase
        end
    end

    assign held_s = held_r;
`else
    logic unused_cfg_s;

    assign rpt_event_s  = 1'b0;
    assign held_s       = 2'd0;
    assign unused_cfg_s = ^{delay_last, period_last};
`endif

    // FIFO handshake: a pop frees a slot for a push on the same edge
    always_comb begin
        push_s   = press_s | rpt_event_s;
        pop_s    = (count_r != 2'd0) && cmd.cmd_ready;
        accept_s = push_s && ((count_r != 2'd2) || pop_s);
        if (press_s) begin
            push_dir_s = press_dir_s;
        end else begin
            push_dir_s = held_s;
        end
    end

    // Two-entry circular FIFO and drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0]   <= 2'd0;
            mem_r[1]   <= 2'd0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            cmd_drop_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_dir_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
            cmd_drop_r <= push_s & ~accept_s;
        end
    end

    assign cmd.cmd_valid = (count_r != 2'd0);
    assign cmd.cmd_dir   = mem_r[rd_ptr_r];
    assign cmd.cmd_drop  = cmd_drop_r;

endmodule
